// File: rtl/multiply_tokens.sv
`default_nettype none
// ============================================================================
// Module   : multiply_tokens
// Purpose  : Per-channel serial token multiplier. Every '1' sampled on a[i]
//            produces MULT consecutive '1's on b[i], one cycle later. Ones that
//            arrive while earlier ones are still being emitted are queued in a
//            pending counter, so a run of R ones yields R*MULT output ones.
//            If the pending count would exceed MAX_RUN*(MULT-1), the channel
//            raises a sticky overflow flag, freezes its counter and silences
//            its output.
// Ports    : clk       - single clock, all state on posedge
//            rst_n     - asynchronous, active-low reset
//            clr       - (only with MULTIPLY_TOKENS_CLEAR_EN) per-channel
//                        synchronous clear of overflow, pending and b
//            a[CH]     - serial token input, bit i = channel i
//            b[CH]     - serial multiplied-token output
//            overflow  - per-channel sticky overflow flag
//            busy      - per-channel, high while pending count is nonzero
// Macro    : MULTIPLY_TOKENS_CLEAR_EN adds the clr input.
// Revision : 1.0 - initial release
// ============================================================================
module multiply_tokens #(
  parameter int CH      = 1,
  parameter int MULT    = 2,
  parameter int MAX_RUN = 200
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef MULTIPLY_TOKENS_CLEAR_EN
  input  logic [CH-1:0] clr,
`endif
  input  logic [CH-1:0] a,
  output logic [CH-1:0] b,
  output logic [CH-1:0] overflow,
  output logic [CH-1:0] busy
);

  // Largest value the pending counter ever has to hold.
  localparam int PEND_MAX = MAX_RUN * (MULT - 1);
  // Counter width; a MULT=1 build still gets a 1-bit counter that stays 0.
  localparam int PW = (PEND_MAX < 1) ? 1 : $clog2(PEND_MAX + 1);
  // One extra bit on the sum so the overflow compare cannot wrap.
  localparam logic [PW:0] INC   = (PW + 1)'(MULT - 1);
  localparam logic [PW:0] LIMIT = (PW + 1)'(PEND_MAX);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [PW-1:0] pend;
    logic          b_q;
    logic          ovf;
    logic [PW:0]   sum;
    logic          will_ovf;
    logic          clr_i;

`ifdef MULTIPLY_TOKENS_CLEAR_EN
    assign clr_i = clr[i];
`else
    assign clr_i = 1'b0;
`endif

    // The current '1' is emitted immediately, so only MULT-1 extra outputs
    // are queued per accepted input token.
    assign sum      = {1'b0, pend} + INC;
    assign will_ovf = a[i] && (sum > LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pend <= '0;
        b_q  <= 1'b0;
        ovf  <= 1'b0;
      end else if (clr_i) begin
        // Clear wins over a new input token on the same edge.
        pend <= '0;
        b_q  <= 1'b0;
        ovf  <= 1'b0;
      end else if (!ovf) begin
        if (will_ovf) begin
          // Setting edge: counter is left untouched, output goes silent.
          ovf <= 1'b1;
          b_q <= 1'b0;
        end else if (a[i]) begin
          b_q  <= 1'b1;
          pend <= sum[PW-1:0];
        end else if (pend != '0) begin
          b_q  <= 1'b1;
          pend <= pend - PW'(1);
        end else begin
          b_q  <= 1'b0;
        end
      end
      // While ovf is set everything holds until reset or clear.
    end

    // Output is gated combinationally so nothing leaks out of a channel
    // that has overflowed.
    assign b[i]        = b_q & ~ovf;
    assign overflow[i] = ovf;
    assign busy[i]     = (pend != '0);
  end

endmodule
`default_nettype wire
